// File: rtl/keyer_pkg.sv
// Shared types and constants for the iambic keyer: FSM states, element codes
// and element/gap lengths expressed in units.
package keyer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIT  = 2'd1,
        ST_DAH  = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

    localparam logic [1:0] ELEM_NONE = 2'b00;
    localparam logic [1:0] ELEM_DIT  = 2'b01;
    localparam logic [1:0] ELEM_DAH  = 2'b10;

    localparam logic [1:0] DIT_UNITS = 2'd1;
    localparam logic [1:0] DAH_UNITS = 2'd3;
    localparam logic [1:0] GAP_UNITS = 2'd1;

    function automatic logic [1:0] elemUnits(input logic [1:0] elem);
        return (elem == ELEM_DAH) ? DAH_UNITS : DIT_UNITS;
    endfunction

endpackage

// File: rtl/element_timer.sv
// Times one keyer phase of units_i x len_i clock cycles; shared by elements and gaps.
// done_o is high only on the final cycle of the phase.
module element_timer
    import keyer_pkg::*;
#(
    parameter int unsigned UnitW = 16
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             start_i,
    input  logic [UnitW-1:0] len_i,
    input  logic [1:0]       units_i,
    output logic             done_o
);

    localparam logic [UnitW-1:0] LenOne = UnitW'(1);

    logic [UnitW-1:0] len_q, len_d;
    logic [UnitW-1:0] unitCnt_q, unitCnt_d;
    logic [1:0]       units_q, units_d;
    logic [1:0]       elemCnt_q, elemCnt_d;
    logic             active_q, active_d;

    logic [UnitW-1:0] lenLast;
    logic [1:0]       unitsLast;
    logic             unitLast;
    logic             elemLast;

    // A zero length or unit count is clamped so the phase still lasts one cycle.
    assign lenLast   = (len_q == '0) ? '0 : (len_q - LenOne);
    assign unitsLast = (units_q < DIT_UNITS) ? 2'd0 : (units_q - DIT_UNITS);
    assign unitLast  = (unitCnt_q == lenLast);
    assign elemLast  = (elemCnt_q == unitsLast);
    assign done_o    = active_q & unitLast & elemLast;

    always_comb begin
        len_d     = len_q;
        units_d   = units_q;
        unitCnt_d = unitCnt_q;
        elemCnt_d = elemCnt_q;
        active_d  = active_q;
        if (start_i) begin
            len_d     = len_i;
            units_d   = units_i;
            unitCnt_d = '0;
            elemCnt_d = '0;
            active_d  = 1'b1;
        end else if (active_q) begin
            if (done_o) begin
                active_d = 1'b0;
            end else if (unitLast) begin
                unitCnt_d = '0;
                elemCnt_d = elemCnt_q + 2'd1;
            end else begin
                unitCnt_d = unitCnt_q + LenOne;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            len_q     <= '0;
            units_q   <= '0;
            unitCnt_q <= '0;
            elemCnt_q <= '0;
            active_q  <= 1'b0;
        end else begin
            len_q     <= len_d;
            units_q   <= units_d;
            unitCnt_q <= unitCnt_d;
            elemCnt_q <= elemCnt_d;
            active_q  <= active_d;
        end
    end

endmodule

// File: rtl/iambic_keyer.sv
// Iambic paddle sequencer: arbitrates dit/dah paddles into timed key-down
// elements with inter-element gaps and optional mode-B squeeze memory.
module iambic_keyer
    import keyer_pkg::*;
#(
    parameter int unsigned UnitW = 16
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             dit_i,
    input  logic             dah_i,
    input  logic             mode_b_i,
    input  logic             en_i,
    input  logic [UnitW-1:0] unit_len_i,
    output logic             key_o,
    output logic             busy_o,
    output logic [1:0]       elem_o
);

    localparam logic [UnitW-1:0] LenOne = UnitW'(1);

    state_e           state_q, state_d;
    logic [1:0]       lastElem_q, lastElem_d;
    logic             ditMem_q, ditMem_d;
    logic             dahMem_q, dahMem_d;
    logic [UnitW-1:0] len_q, len_d;
    logic             key_q;

    logic             timerStart;
    logic [UnitW-1:0] timerLen;
    logic [1:0]       timerUnits;
    logic             timerDone;

    logic [UnitW-1:0] effLen;
    logic             inDitPhase;
    logic             inDahPhase;
    logic             reqDit;
    logic             reqDah;

    assign effLen     = (unit_len_i == '0) ? LenOne : unit_len_i;
    assign inDitPhase = (state_q == ST_DIT) || ((state_q == ST_GAP) && (lastElem_q == ELEM_DIT));
    assign inDahPhase = (state_q == ST_DAH) || ((state_q == ST_GAP) && (lastElem_q == ELEM_DAH));
    // Memories only count in mode B, even if one was set just before a mode change.
    assign reqDit     = dit_i | (ditMem_q & mode_b_i);
    assign reqDah     = dah_i | (dahMem_q & mode_b_i);

    element_timer #(
        .UnitW (UnitW)
    ) u_timer (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .start_i (timerStart),
        .len_i   (timerLen),
        .units_i (timerUnits),
        .done_o  (timerDone)
    );

    always_comb begin
        state_d    = state_q;
        lastElem_d = lastElem_q;
        len_d      = len_q;
        ditMem_d   = ditMem_q;
        dahMem_d   = dahMem_q;
        timerStart = 1'b0;
        timerLen   = len_q;
        timerUnits = GAP_UNITS;

        if (mode_b_i) begin
            if (inDitPhase && dah_i) dahMem_d = 1'b1;
            if (inDahPhase && dit_i) ditMem_d = 1'b1;
        end else begin
            ditMem_d = 1'b0;
            dahMem_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (en_i && dit_i)      state_d = ST_DIT;
                else if (en_i && dah_i) state_d = ST_DAH;
            end
            ST_DIT: begin
                if (timerDone) begin
                    state_d    = ST_GAP;
                    lastElem_d = ELEM_DIT;
                end
            end
            ST_DAH: begin
                if (timerDone) begin
                    state_d    = ST_GAP;
                    lastElem_d = ELEM_DAH;
                end
            end
            ST_GAP: begin
                // Alternation uses memory plus live level; repetition uses live level only.
                if (timerDone) begin
                    if (lastElem_q == ELEM_DIT) begin
                        if (en_i && reqDah)     state_d = ST_DAH;
                        else if (en_i && dit_i) state_d = ST_DIT;
                        else                    state_d = ST_IDLE;
                    end else begin
                        if (en_i && reqDit)     state_d = ST_DIT;
                        else if (en_i && dah_i) state_d = ST_DAH;
                        else                    state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d != state_q) begin
            unique case (state_d)
                ST_DIT: begin
                    timerStart = 1'b1;
                    timerLen   = effLen;
                    timerUnits = elemUnits(ELEM_DIT);
                    len_d      = effLen;
                    ditMem_d   = 1'b0;
                end
                ST_DAH: begin
                    timerStart = 1'b1;
                    timerLen   = effLen;
                    timerUnits = elemUnits(ELEM_DAH);
                    len_d      = effLen;
                    dahMem_d   = 1'b0;
                end
                ST_GAP: begin
                    timerStart = 1'b1;
                    timerLen   = len_q;
                    timerUnits = GAP_UNITS;
                end
                default: begin
                    ditMem_d   = 1'b0;
                    dahMem_d   = 1'b0;
                    lastElem_d = ELEM_NONE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= ST_IDLE;
            lastElem_q <= ELEM_NONE;
            ditMem_q   <= 1'b0;
            dahMem_q   <= 1'b0;
            len_q      <= LenOne;
            key_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lastElem_q <= lastElem_d;
            ditMem_q   <= ditMem_d;
            dahMem_q   <= dahMem_d;
            len_q      <= len_d;
            key_q      <= (state_d == ST_DIT) || (state_d == ST_DAH);
        end
    end

    always_comb begin
        elem_o = ELEM_NONE;
        unique case (state_q)
            ST_DIT:  elem_o = ELEM_DIT;
            ST_DAH:  elem_o = ELEM_DAH;
            ST_GAP:  elem_o = lastElem_q;
            default: elem_o = ELEM_NONE;
        endcase
    end

    assign key_o  = key_q;
    assign busy_o = (state_q != ST_IDLE);

endmodule
